// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core: sequences ALU, register file,
// memory port and PC, and counts retired instructions.
module multicycle_control #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          op,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                Zero,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [2:0]          ALUControl,
  output logic [1:0]          ResultSrc,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic [RETIRE_W-1:0] instret,
  output logic [3:0]          state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t                state_q, state_d;
  logic [RETIRE_W-1:0]   instret_q, instret_d;
  logic [1:0]            alu_op;
  logic                  pc_update;
  logic                  branch;
  logic                  ir_write;
  logic                  reg_write;
  logic                  mem_write;
  logic                  retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Unused encodings 11-15 fall through the default and recover to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECUTER;
          7'b0010011:             state_d = S_EXECUTEI;
          7'b1100011:             state_d = S_BEQ;
          7'b1101111:             state_d = S_JAL;
          default:                state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    alu_op    = 2'b00;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  // Only R-type (op[5]=1) may subtract on funct3=000; addi ignores Instr[30].
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    retire    = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                (state_q == S_ALUWB) || (state_q == S_BEQ);
    instret_d = retire ? instret_q + RETIRE_W'(1) : instret_q;
  end

  assign IRWrite  = ir_write & ~reset;
  assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign instret  = instret_q;
  assign state_o  = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Decodes op/funct fields from the instruction register and sequences the shared ALU, register file, memory port and PC.
- Drives ImmSrc to the immediate extender: 00 I, 01 S, 10 B, 11 J.
- Also keeps a retired-instruction counter for debug and performance.

Parameters:
RETIRE_W, 32, width of the retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  7  Instr[6:0]
funct3  input  3  Instr[14:12]
funct7b5  input  1  Instr[30]
Zero  input  1  ALU zero flag
ImmSrc  output  2  immediate format select to extender
ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 data
ALUSrcB  output  2  00 rs2 data, 01 ImmExt, 10 constant 4
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
AdrSrc  output  1  0 PC, 1 Result
IRWrite  output  1  latch instruction and OldPC
PCWrite  output  1  PC load enable
RegWrite  output  1  register-file write enable
MemWrite  output  1  data-memory write enable
instret  output  RETIRE_W  count of completed instructions
state_o  output  4  current state encoding (debug)

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10
  - Codes 11-15 are illegal and go to FETCH on the next edge.
- Reset:
  - Asynchronous; state goes to FETCH and instret to 0 immediately.
  - While reset=1, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0.
  - Other outputs take their FETCH values.
  - Reset mid-instruction abandons it with no retire.
- Outputs are Moore (from state). Exceptions:
  - ImmSrc is combinational from op.
  - ALUControl is combinational from ALUOp/funct.
  - PCWrite is combinational (see Branch below).
- Unlisted outputs are 0 in every state.
- Per-state outputs and transitions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target). Next by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> FETCH (no writes, no retire)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH (retire).
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH (retire).
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH (retire).
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH (retire).
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- Branch: PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc decode:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - all other op -> 00
- ALU decode:
  - ALUOp=00 -> add; ALUOp=01 -> sub.
  - ALUOp=10, by funct3:
    - 000: sub if op[5]&funct7b5, else add (addi never subtracts)
    - 010: slt
    - 110: or
    - 111: and
    - other: add
  - ALUOp=11 -> add.
- Latencies (cycles, FETCH to FETCH):
  - lw 5; sw 4; R-type 4; I-ALU 4; beq 3; jal 4; illegal op 2.
- instret increments by 1 on the clock edge leaving MEMWB, MEMWRITE, ALUWB or BEQ; it wraps from 2^RETIRE_W-1 to 0.

Test Plan:
- Reset asserted for 1.5 cycles mid-MEMREAD -> state_o=0 and instret=0 asynchronously; all write enables 0 during reset; IRWrite=1 in the first cycle after release.
- lw (op=0000011) -> states 0,1,2,3,4; RegWrite=1 only in MEMWB with ResultSrc=01; ImmSrc=00; instret=1 after 5 cycles.
- sw (op=0100011) -> states 0,1,2,5; MemWrite=1 for exactly one cycle with AdrSrc=1; ImmSrc=01.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER; addi with Instr[30]=1 -> ALUControl=000; funct3=110 -> 011; funct3=111 -> 010; funct3=010 -> 101.
- beq with Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; ImmSrc=10; 3 cycles each; instret +1 either way.
- jal -> states 0,1,10,8; PCWrite=1 in JAL; ImmSrc=11; op=1111111 -> back to FETCH after DECODE with no write enables and instret unchanged; instret preloaded at all-ones wraps to 0 on next retire.
